// File: rtl/ahblite_block_ram_v2.sv
// AHB-Lite slave bridge onto a simple dual-port block RAM.
// Zero-wait writes, 1- or 2-cycle reads, and write-to-read forwarding.
module ahblite_block_ram_v2 #(
   parameter int ADDR_WIDTH    = 12,
   parameter int RD_LATENCY    = 1,
   parameter int ERR_UNALIGNED = 1
) (
   input  logic                  HCLK,
   input  logic                  HRESET,
   input  logic                  HSEL,
   input  logic [31:0]           HADDR,
   input  logic [1:0]            HTRANS,
   input  logic [2:0]            HSIZE,
   input  logic                  HWRITE,
   input  logic [31:0]           HWDATA,
   input  logic                  HREADY,
   output logic                  HREADYOUT,
   output logic [31:0]           HRDATA,
   output logic [1:0]            HRESP,
   output logic [ADDR_WIDTH-1:0] BRAM_RDADDR,
   output logic [ADDR_WIDTH-1:0] BRAM_WRADDR,
   input  logic [31:0]           BRAM_RDATA,
   output logic [31:0]           BRAM_WDATA,
   output logic [3:0]            BRAM_WRITE
);

   typedef enum logic [1:0] {IDLE, RWAIT, ERR1, ERR2} state_t;

   state_t                  state;
   logic                    hready_q;
   logic                    err_q;
   logic                    wr_pend;
   logic [ADDR_WIDTH-1:0]   wr_addr;
   logic [3:0]              wr_strb;
   logic [ADDR_WIDTH-1:0]   rd_addr;
   logic                    rd_valid;
   logic [31:0]             haz_data;
   logic [3:0]              haz_strb;

   logic                    accept;
   logic                    aligned;
   logic [3:0]              strb;
   logic                    ok_acc;
   logic                    bad_acc;
   logic                    rd_acc;
   logic [ADDR_WIDTH-1:0]   waddr;
   logic [31:0]             merged;
   logic                    unused_ok;

   assign unused_ok = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

   // Our own ready gates acceptance so stalled cycles ignore the bus.
   assign accept  = HSEL & HTRANS[1] & HREADY & hready_q;
   assign waddr   = HADDR[ADDR_WIDTH+1:2];
   assign ok_acc  = accept & aligned;
   assign bad_acc = accept & ~aligned;
   assign rd_acc  = ok_acc & ~HWRITE;

   always_comb begin
      strb    = 4'h0;
      aligned = 1'b1;
      case (HSIZE)
         3'd0: strb = 4'b0001 << HADDR[1:0];
         3'd1: begin
            if (HADDR[1:0] == 2'b00)      strb = 4'h3;
            else if (HADDR[1:0] == 2'b10) strb = 4'hC;
            else                          aligned = 1'b0;
         end
         3'd2: begin
            if (HADDR[1:0] == 2'b00) strb = 4'hF;
            else                     aligned = 1'b0;
         end
         default: aligned = 1'b0;
      endcase
   end

   always_comb begin
      merged = BRAM_RDATA;
      for (int i = 0; i < 4; i++) begin
         if (haz_strb[i]) merged[8*i +: 8] = haz_data[8*i +: 8];
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state    <= IDLE;
         hready_q <= 1'b1;
         err_q    <= 1'b0;
         wr_pend  <= 1'b0;
         wr_addr  <= '0;
         wr_strb  <= 4'h0;
         rd_addr  <= '0;
         rd_valid <= 1'b0;
         haz_data <= 32'h0;
         haz_strb <= 4'h0;
      end else begin
         wr_pend <= ok_acc & HWRITE;
         if (ok_acc) begin
            wr_addr <= waddr;
            wr_strb <= strb;
         end
         // A read landing on the word being written this cycle sees old RAM data.
         if (rd_acc) begin
            rd_addr  <= waddr;
            haz_data <= HWDATA;
            haz_strb <= (wr_pend && wr_addr == waddr) ? wr_strb : 4'h0;
         end
         rd_valid <= (RD_LATENCY == 1) ? rd_acc : (state == RWAIT);
         case (state)
            RWAIT: begin
               state    <= IDLE;
               hready_q <= 1'b1;
               err_q    <= 1'b0;
            end
            ERR1: begin
               state    <= ERR2;
               hready_q <= 1'b1;
               err_q    <= 1'b1;
            end
            default: begin
               if (bad_acc && ERR_UNALIGNED != 0) begin
                  state    <= ERR1;
                  hready_q <= 1'b0;
                  err_q    <= 1'b1;
               end else if (rd_acc && RD_LATENCY == 2) begin
                  state    <= RWAIT;
                  hready_q <= 1'b0;
                  err_q    <= 1'b0;
               end else begin
                  state    <= IDLE;
                  hready_q <= 1'b1;
                  err_q    <= 1'b0;
               end
            end
         endcase
      end
   end

   assign HREADYOUT   = hready_q;
   assign HRESP       = {1'b0, err_q};
   assign HRDATA      = rd_valid ? merged : 32'h0;
   assign BRAM_RDADDR = (state == RWAIT) ? rd_addr : waddr;
   assign BRAM_WRADDR = wr_addr;
   assign BRAM_WDATA  = HWDATA;
   assign BRAM_WRITE  = (wr_pend && !HRESET) ? wr_strb : 4'h0;

endmodule

// File: tb/tb_ahblite_block_ram_v2.sv
// Bench for ahblite_block_ram_v2: one 1-cycle/ERROR instance and
// one 2-cycle/silent-unaligned instance, each with its own RAM model.
module tb_ahblite_block_ram_v2;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        hreset = 1'b1;
   logic        hsel   = 1'b0;
   logic        dsel   = 1'b0;
   logic        hwrite = 1'b0;
   logic [31:0] haddr  = 32'h0;
   logic [31:0] hwdata = 32'h0;
   logic [1:0]  htrans = 2'b00;
   logic [2:0]  hsize  = 3'd0;

   logic        ho1, ho2;
   logic [31:0] rd1, rd2;
   logic [1:0]  rs1, rs2;
   logic [11:0] ra1, ra2, wa1, wa2;
   logic [31:0] wd1, wd2;
   logic [3:0]  we1, we2;
   logic [31:0] bq1, bq2, bp2;

   logic        hreadyout;
   logic [31:0] hrdata;
   logic [1:0]  hresp;
   logic [3:0]  bram_write;
   logic [11:0] bram_wraddr;

   ahblite_block_ram_v2 #(.ADDR_WIDTH(12), .RD_LATENCY(1), .ERR_UNALIGNED(1)) u1 (
      .HCLK(clk), .HRESET(hreset), .HSEL(hsel & ~dsel), .HADDR(haddr),
      .HTRANS(htrans), .HSIZE(hsize), .HWRITE(hwrite), .HWDATA(hwdata),
      .HREADY(ho1), .HREADYOUT(ho1), .HRDATA(rd1), .HRESP(rs1),
      .BRAM_RDADDR(ra1), .BRAM_WRADDR(wa1), .BRAM_RDATA(bq1),
      .BRAM_WDATA(wd1), .BRAM_WRITE(we1));

   ahblite_block_ram_v2 #(.ADDR_WIDTH(12), .RD_LATENCY(2), .ERR_UNALIGNED(0)) u2 (
      .HCLK(clk), .HRESET(hreset), .HSEL(hsel & dsel), .HADDR(haddr),
      .HTRANS(htrans), .HSIZE(hsize), .HWRITE(hwrite), .HWDATA(hwdata),
      .HREADY(ho2), .HREADYOUT(ho2), .HRDATA(rd2), .HRESP(rs2),
      .BRAM_RDADDR(ra2), .BRAM_WRADDR(wa2), .BRAM_RDATA(bq2),
      .BRAM_WDATA(wd2), .BRAM_WRITE(we2));

   assign hreadyout   = dsel ? ho2 : ho1;
   assign hrdata      = dsel ? rd2 : rd1;
   assign hresp       = dsel ? rs2 : rs1;
   assign bram_write  = dsel ? we2 : we1;
   assign bram_wraddr = dsel ? wa2 : wa1;

   // Read-first RAM models: one-cycle and two-cycle read pipes.
   bit [31:0] mem1 [0:4095];
   bit [31:0] mem2 [0:4095];

   always @(posedge clk) begin
      bq1 <= mem1[ra1];
      for (int i = 0; i < 4; i++)
         if (we1[i]) mem1[wa1][8*i +: 8] <= wd1[8*i +: 8];
   end

   always @(posedge clk) begin
      bp2 <= mem2[ra2];
      bq2 <= bp2;
      for (int i = 0; i < 4; i++)
         if (we2[i]) mem2[wa2][8*i +: 8] <= wd2[8*i +: 8];
   end

   typedef struct {
      logic        dsel;
      logic        wr;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [11:0] wa;
      logic [31:0] rdata;
      logic [1:0]  resp;
      int          waits;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic [1:0]  resp;
      int          waits;
   } exp_t;

   exp_t sb[$];
   int   total  = 0;
   int   passed = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h", nm, act, exp);
   endtask

   task automatic complete(input string nm);
      int   w;
      exp_t e;
      w = 0;
      while (hreadyout !== 1'b1 && w < 8) begin
         w++;
         @(negedge clk);
      end
      if (sb.size() == 0) begin
         chk($sformatf("%s.sb_empty", nm), 32'h1, 32'h0);
      end else begin
         e = sb.pop_front();
         chk($sformatf("%s.waits", nm), w, e.waits);
         chk($sformatf("%s.resp", nm), {30'h0, hresp}, {30'h0, e.resp});
         chk($sformatf("%s.rdata", nm), hrdata, e.rdata);
      end
   endtask

   task automatic xfer(input vec_t v, input string nm);
      @(posedge clk); #1;
      hsel = 1'b1; htrans = 2'b10; haddr = v.addr;
      hsize = v.size; hwrite = v.wr;
      sb.push_back('{v.rdata, v.resp, v.waits});
      @(posedge clk); #1;
      hsel = 1'b0; htrans = 2'b00; hwdata = v.wdata;
      @(negedge clk);
      chk($sformatf("%s.strb", nm), {28'h0, bram_write}, {28'h0, v.strb});
      if (v.strb != 4'h0)
         chk($sformatf("%s.wraddr", nm), {20'h0, bram_wraddr}, {20'h0, v.wa});
      if (hreadyout !== 1'b1)
         chk($sformatf("%s.wresp", nm), {30'h0, hresp}, {30'h0, v.resp});
      complete(nm);
   endtask

   // Write immediately followed by a word read in the write's data phase.
   task automatic b2b(input string nm, input logic [31:0] waddr,
                      input logic [2:0] wsz, input logic [31:0] wd,
                      input logic [3:0] strb, input logic [31:0] raddr,
                      input logic [31:0] exp, input int ew);
      @(posedge clk); #1;
      hsel = 1'b1; htrans = 2'b10; haddr = waddr; hsize = wsz; hwrite = 1'b1;
      @(posedge clk); #1;
      hwdata = wd; haddr = raddr; hsize = 3'd2; hwrite = 1'b0;
      sb.push_back('{exp, 2'b00, ew});
      @(negedge clk);
      chk($sformatf("%s.strb", nm), {28'h0, bram_write}, {28'h0, strb});
      chk($sformatf("%s.rdy", nm), {31'h0, hreadyout}, 32'h1);
      @(posedge clk); #1;
      hsel = 1'b0; htrans = 2'b00;
      @(negedge clk);
      complete(nm);
   endtask

   vec_t tbl [22];
   vec_t v;

   initial begin
      tbl[0]  = '{0, 1, 32'h10,   3'd2, 32'hDEADBEEF, 4'hF, 12'h004, 32'h0,        2'b00, 0};
      tbl[1]  = '{0, 0, 32'h10,   3'd2, 32'h0,        4'h0, 12'h000, 32'hDEADBEEF, 2'b00, 0};
      tbl[2]  = '{0, 1, 32'h13,   3'd0, 32'hAA000000, 4'h8, 12'h004, 32'h0,        2'b00, 0};
      tbl[3]  = '{0, 0, 32'h10,   3'd2, 32'h0,        4'h0, 12'h000, 32'hAAADBEEF, 2'b00, 0};
      tbl[4]  = '{0, 1, 32'h12,   3'd1, 32'h12340000, 4'hC, 12'h004, 32'h0,        2'b00, 0};
      tbl[5]  = '{0, 0, 32'h10,   3'd2, 32'h0,        4'h0, 12'h000, 32'h1234BEEF, 2'b00, 0};
      tbl[6]  = '{0, 1, 32'h11,   3'd0, 32'h00005500, 4'h2, 12'h004, 32'h0,        2'b00, 0};
      tbl[7]  = '{0, 0, 32'h10,   3'd1, 32'h0,        4'h0, 12'h000, 32'h123455EF, 2'b00, 0};
      tbl[8]  = '{0, 0, 32'h21,   3'd2, 32'h0,        4'h0, 12'h000, 32'h0,        2'b01, 1};
      tbl[9]  = '{0, 1, 32'h11,   3'd1, 32'hFFFFFFFF, 4'h0, 12'h000, 32'h0,        2'b01, 1};
      tbl[10] = '{0, 0, 32'h10,   3'd2, 32'h0,        4'h0, 12'h000, 32'h123455EF, 2'b00, 0};
      tbl[11] = '{0, 1, 32'h4010, 3'd2, 32'hCAFEF00D, 4'hF, 12'h004, 32'h0,        2'b00, 0};
      tbl[12] = '{0, 0, 32'h10,   3'd2, 32'h0,        4'h0, 12'h000, 32'hCAFEF00D, 2'b00, 0};
      tbl[13] = '{0, 0, 32'h0,    3'd3, 32'h0,        4'h0, 12'h000, 32'h0,        2'b01, 1};
      tbl[14] = '{0, 1, 32'h3FFC, 3'd2, 32'h0BADF00D, 4'hF, 12'hFFF, 32'h0,        2'b00, 0};
      tbl[15] = '{0, 0, 32'h3FFC, 3'd2, 32'h0,        4'h0, 12'h000, 32'h0BADF00D, 2'b00, 0};
      tbl[16] = '{0, 1, 32'h22,   3'd2, 32'h55555555, 4'h0, 12'h000, 32'h0,        2'b01, 1};
      tbl[17] = '{1, 1, 32'h40,   3'd2, 32'h87654321, 4'hF, 12'h010, 32'h0,        2'b00, 0};
      tbl[18] = '{1, 0, 32'h40,   3'd2, 32'h0,        4'h0, 12'h000, 32'h87654321, 2'b00, 1};
      tbl[19] = '{1, 0, 32'h41,   3'd2, 32'h0,        4'h0, 12'h000, 32'h0,        2'b00, 0};
      tbl[20] = '{1, 1, 32'h42,   3'd2, 32'hFFFFFFFF, 4'h0, 12'h000, 32'h0,        2'b00, 0};
      tbl[21] = '{1, 0, 32'h40,   3'd2, 32'h0,        4'h0, 12'h000, 32'h87654321, 2'b00, 1};

      repeat (2) @(posedge clk);
      #1 hreset = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         dsel = d[0];
         #1;
         chk($sformatf("rst%0d.rdy", d), {31'h0, hreadyout}, 32'h1);
         chk($sformatf("rst%0d.resp", d), {30'h0, hresp}, 32'h0);
         chk($sformatf("rst%0d.we", d), {28'h0, bram_write}, 32'h0);
         chk($sformatf("rst%0d.rdata", d), hrdata, 32'h0);
      end

      for (int i = 0; i < 22; i++) begin
         dsel = tbl[i].dsel;
         xfer(tbl[i], $sformatf("v%0d", i));
      end

      dsel = 1'b0;
      b2b("haz_word", 32'h20, 3'd2, 32'h11223344, 4'hF, 32'h20, 32'h11223344, 0);
      v = '{0, 1, 32'h30, 3'd2, 32'hAABBCCDD, 4'hF, 12'h00C, 32'h0, 2'b00, 0};
      xfer(v, "pre30");
      b2b("haz_byte", 32'h30, 3'd0, 32'h000000EE, 4'h1, 32'h30, 32'hAABBCCEE, 0);
      b2b("wr_rd_diff", 32'h50, 3'd2, 32'h01020304, 4'hF, 32'h10, 32'hCAFEF00D, 0);
      v = '{0, 0, 32'h20, 3'd2, 32'h0, 4'h0, 12'h000, 32'h11223344, 2'b00, 0};
      xfer(v, "rb20");

      // Read then write with no bubble between them.
      @(posedge clk); #1;
      hsel = 1'b1; htrans = 2'b10; haddr = 32'h10; hsize = 3'd2; hwrite = 1'b0;
      @(posedge clk); #1;
      haddr = 32'h54; hwrite = 1'b1;
      @(negedge clk);
      chk("rw.rdata", hrdata, 32'hCAFEF00D);
      chk("rw.we0", {28'h0, bram_write}, 32'h0);
      @(posedge clk); #1;
      hsel = 1'b0; htrans = 2'b00; hwdata = 32'h13572468;
      @(negedge clk);
      chk("rw.we1", {28'h0, bram_write}, 32'hF);
      chk("rw.wraddr", {20'h0, bram_wraddr}, 32'h15);
      chk("rw.rdata0", hrdata, 32'h0);
      v = '{0, 0, 32'h54, 3'd2, 32'h0, 4'h0, 12'h000, 32'h13572468, 2'b00, 0};
      xfer(v, "rb54");

      // Reset during a write data phase must suppress the write.
      @(posedge clk); #1;
      hsel = 1'b1; htrans = 2'b10; haddr = 32'h60; hsize = 3'd2; hwrite = 1'b1;
      @(posedge clk); #1;
      hsel = 1'b0; htrans = 2'b00; hwdata = 32'h55555555; hreset = 1'b1;
      @(negedge clk);
      chk("rstw.we0", {28'h0, bram_write}, 32'h0);
      @(posedge clk); #1;
      hreset = 1'b0;
      @(negedge clk);
      chk("rstw.we1", {28'h0, bram_write}, 32'h0);
      chk("rstw.rdy", {31'h0, hreadyout}, 32'h1);
      chk("rstw.resp", {30'h0, hresp}, 32'h0);
      chk("rstw.rdata", hrdata, 32'h0);
      v = '{0, 0, 32'h60, 3'd2, 32'h0, 4'h0, 12'h000, 32'h0, 2'b00, 0};
      xfer(v, "rb60");

      // Reset while in the first ERROR cycle.
      @(posedge clk); #1;
      hsel = 1'b1; htrans = 2'b10; haddr = 32'h21; hsize = 3'd2; hwrite = 1'b0;
      @(posedge clk); #1;
      hsel = 1'b0; htrans = 2'b00;
      @(negedge clk);
      chk("rste.rdy0", {31'h0, hreadyout}, 32'h0);
      chk("rste.resp0", {30'h0, hresp}, 32'h1);
      #1 hreset = 1'b1;
      @(posedge clk); #1;
      hreset = 1'b0;
      @(negedge clk);
      chk("rste.rdy1", {31'h0, hreadyout}, 32'h1);
      chk("rste.resp1", {30'h0, hresp}, 32'h0);

      dsel = 1'b1;
      b2b("haz_l2", 32'h44, 3'd2, 32'h0F0F0F0F, 4'hF, 32'h44, 32'h0F0F0F0F, 1);

      // RWAIT must hold the captured read address on the RAM port.
      @(posedge clk); #1;
      hsel = 1'b1; htrans = 2'b10; haddr = 32'h40; hsize = 3'd2; hwrite = 1'b0;
      @(posedge clk); #1;
      hsel = 1'b0; htrans = 2'b00; haddr = 32'h0;
      @(negedge clk);
      chk("rwait.addr", {20'h0, ra2}, 32'h10);
      chk("rwait.rdy", {31'h0, hreadyout}, 32'h0);
      chk("rwait.rdata", hrdata, 32'h0);
      @(negedge clk);
      chk("rwait.done", {31'h0, hreadyout}, 32'h1);
      chk("rwait.data", hrdata, 32'h87654321);

      chk("sb.left", sb.size(), 32'h0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
